// File: rtl/gb_joypad_pkg.sv
// Shared constants for the Game Boy joypad block: register address,
// SNES bit positions and the nibble-mapping helpers.
package gb_joypad_pkg;

    localparam logic [15:0] JOYP_ADDR = 16'hFF00;

    localparam int SNES_B      = 0;
    localparam int SNES_Y      = 1;
    localparam int SNES_SELECT = 2;
    localparam int SNES_START  = 3;
    localparam int SNES_UP     = 4;
    localparam int SNES_DOWN   = 5;
    localparam int SNES_LEFT   = 6;
    localparam int SNES_RIGHT  = 7;
    localparam int SNES_A      = 8;
    localparam int SNES_X      = 9;
    localparam int SNES_L      = 10;
    localparam int SNES_R      = 11;

    // Bits 15:12 are all ones when a controller is actually attached.
    localparam logic [15:0] SNES_PRESENT_MASK = 16'hF000;

    // Active-low D-pad nibble {Down, Up, Left, Right}.
    function automatic logic [3:0] dpad_nib(input logic [11:0] s);
        return {s[SNES_DOWN], s[SNES_UP], s[SNES_LEFT], s[SNES_RIGHT]};
    endfunction

    // Active-low button nibble {Start, Select, B, A}.
    function automatic logic [3:0] btn_nib(input logic [11:0] s);
        return {s[SNES_START], s[SNES_SELECT], s[SNES_B], s[SNES_A]};
    endfunction

endpackage

// File: rtl/gb_joypad_debounce.sv
// Vector debounce: the input must hold unchanged for CYCLES edges before
// it is copied to the output. Any change restarts the count.
module joy_debounce #(
    parameter int          WIDTH  = 12,
    parameter int unsigned CYCLES = 4096
) (
    input  logic             clock_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] stable_o
);

    localparam int           CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [WIDTH-1:0] sample_q;
    logic [WIDTH-1:0] stable_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             commit;

    // Restart on any change, otherwise count up and saturate at LAST;
    // commit only once the count has saturated on an unchanged sample.
    always_comb begin
        cnt_d  = cnt_q;
        commit = 1'b0;
        if (raw_i != sample_q) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            commit = 1'b1;
        end
    end

    // Sample history, counter and committed vector.
    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i) begin
            sample_q <= '1;
            cnt_q    <= '0;
            stable_q <= '1;
        end else begin
            sample_q <= raw_i;
            cnt_q    <= cnt_d;
            if (commit) begin
                stable_q <= sample_q;
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/gb_joypad.sv
// P1/JOYP (0xFF00) register: debounced SNES input mapped onto the Game Boy
// matrix, joypad interrupt, wake flag and held-combo soft reset.
module gb_joypad
    import gb_joypad_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd4096,
    parameter logic [23:0] COMBO_CYCLES    = 24'd4_000_000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] addr_bus,
    input  logic [7:0]  data_in,
    input  logic        we,
    input  logic        re,
    input  logic [15:0] snes_buttons,
    output logic [7:0]  data_out,
    output logic        sel,
    output logic        irq_joypad,
    output logic        button_pressed,
    output logic        combo_reset
);

    localparam logic [23:0] COMBO_LAST = COMBO_CYCLES - 24'd1;

    logic [11:0] raw_checked;
    logic [11:0] stable;
    logic [3:0]  dpad;
    logic [3:0]  btns;
    logic [3:0]  low_nib;
    logic        p14_q;
    logic        p15_q;
    logic [3:0]  prev_nib_q;
    logic        irq_q;
    logic        combo_hold;
    logic [23:0] combo_cnt_q;
    logic [23:0] combo_cnt_d;
    logic        combo_rst_q;
    logic        combo_rst_d;
    logic        unused_ok;

    assign sel = (addr_bus == JOYP_ADDR);

    // A missing or floating controller is treated as all buttons released.
    always_comb begin
        raw_checked = 12'hFFF;
        if ((snes_buttons & SNES_PRESENT_MASK) == SNES_PRESENT_MASK) begin
            raw_checked = snes_buttons[11:0];
        end
    end

    joy_debounce #(
        .WIDTH  (12),
        .CYCLES (32'(DEBOUNCE_CYCLES))
    ) u_debounce (
        .clock_i  (clock),
        .rst_i    (rst),
        .raw_i    (raw_checked),
        .stable_o (stable)
    );

    assign dpad    = dpad_nib(stable);
    assign btns    = btn_nib(stable);
    assign low_nib = (p14_q ? 4'hF : dpad) & (p15_q ? 4'hF : btns);

    assign data_out       = sel ? {2'b11, p15_q, p14_q, low_nib} : 8'hFF;
    assign button_pressed = ~&{dpad, btns};
    assign irq_joypad     = irq_q;
    assign combo_reset    = combo_rst_q;

    // Line-select bits, written through the CPU port.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            p14_q <= 1'b1;
            p15_q <= 1'b1;
        end else if (we && sel) begin
            p15_q <= data_in[5];
            p14_q <= data_in[4];
        end
    end

    // Interrupt on any 1->0 transition of the visible nibble, including
    // transitions caused by changing the line select.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            prev_nib_q <= 4'hF;
            irq_q      <= 1'b0;
        end else begin
            prev_nib_q <= low_nib;
            irq_q      <= |(prev_nib_q & ~low_nib);
        end
    end

    // Start+Select+B+A all pressed means the whole button nibble is low.
    assign combo_hold = (btns == 4'h0);

    // Combo hold counter: saturates and raises the request, clears on release.
    always_comb begin
        combo_cnt_d = combo_cnt_q;
        combo_rst_d = combo_rst_q;
        if (!combo_hold) begin
            combo_cnt_d = '0;
            combo_rst_d = 1'b0;
        end else if (combo_cnt_q != COMBO_LAST) begin
            combo_cnt_d = combo_cnt_q + 24'd1;
        end else begin
            combo_rst_d = 1'b1;
        end
    end

    // Combo counter and request registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            combo_cnt_q <= '0;
            combo_rst_q <= 1'b0;
        end else begin
            combo_cnt_q <= combo_cnt_d;
            combo_rst_q <= combo_rst_d;
        end
    end

    // Reads have no side effects, and X/Y/L/R have no Game Boy equivalent.
    assign unused_ok = &{1'b0, re, stable[SNES_X], stable[SNES_Y],
                         stable[SNES_L], stable[SNES_R]};

endmodule

// File: tb/tb_gb_joypad.sv
// Randomized and directed stimulus for gb_joypad, checked by a scoreboard
// fed from a behavioural model of the joypad register.
module tb_gb_joypad;

    localparam int D = 16;
    localparam int C = 40;

    logic        clock;
    logic        rst;
    logic [15:0] addr_bus;
    logic [7:0]  data_in;
    logic        we;
    logic        re;
    logic [15:0] snes_buttons;
    logic [7:0]  data_out;
    logic        sel;
    logic        irq_joypad;
    logic        button_pressed;
    logic        combo_reset;

    gb_joypad #(
        .DEBOUNCE_CYCLES (16'(D)),
        .COMBO_CYCLES    (24'(C))
    ) dut (
        .clock          (clock),
        .rst            (rst),
        .addr_bus       (addr_bus),
        .data_in        (data_in),
        .we             (we),
        .re             (re),
        .snes_buttons   (snes_buttons),
        .data_out       (data_out),
        .sel            (sel),
        .irq_joypad     (irq_joypad),
        .button_pressed (button_pressed),
        .combo_reset    (combo_reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] dout;
        logic       sel;
        logic       irq;
        logic       pressed;
        logic       combo;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Behavioural model state
    logic [11:0] m_stable;
    logic        m_p14, m_p15;
    logic [3:0]  m_nib_prev;
    logic        m_irq, m_combo;
    int          m_held;
    logic [11:0] m_hist[$];

    // Active-low button names -> SNES bit positions
    function automatic logic [3:0] m_dpad();
        return {m_stable[5], m_stable[4], m_stable[6], m_stable[7]};
    endfunction

    function automatic logic [3:0] m_btns();
        return {m_stable[3], m_stable[2], m_stable[0], m_stable[8]};
    endfunction

    function automatic logic [3:0] m_low();
        logic [3:0] a, b;
        a = m_p14 ? 4'hF : m_dpad();
        b = m_p15 ? 4'hF : m_btns();
        return a & b;
    endfunction

    function automatic void model_reset();
        m_stable   = 12'hFFF;
        m_p14      = 1'b1;
        m_p15      = 1'b1;
        m_nib_prev = 4'hF;
        m_irq      = 1'b0;
        m_combo    = 1'b0;
        m_held     = 0;
        m_hist.delete();
        m_hist.push_back(12'hFFF);
    endfunction

    // One clock edge of the model, using the inputs present before the edge.
    function automatic void model_edge();
        logic [3:0]  nib_now;
        logic [11:0] raw;
        logic        same;
        if (rst) begin
            model_reset();
            return;
        end
        nib_now    = m_low();
        m_irq      = |(m_nib_prev & ~nib_now);
        m_nib_prev = nib_now;

        if (!m_stable[3] && !m_stable[2] && !m_stable[8] && !m_stable[0])
            m_held++;
        else
            m_held = 0;
        m_combo = (m_held >= C);

        raw = (snes_buttons[15:12] == 4'hF) ? snes_buttons[11:0] : 12'hFFF;
        m_hist.push_back(raw);
        if (m_hist.size() > D + 1) void'(m_hist.pop_front());
        if (m_hist.size() == D + 1) begin
            same = 1'b1;
            for (int i = 1; i < m_hist.size(); i++)
                if (m_hist[i] != m_hist[0]) same = 1'b0;
            if (same) m_stable = raw;
        end

        if (we && addr_bus == 16'hFF00) begin
            m_p15 = data_in[5];
            m_p14 = data_in[4];
        end
    endfunction

    function automatic void push_expected();
        exp_t e;
        e.sel     = (addr_bus == 16'hFF00);
        e.dout    = e.sel ? {2'b11, m_p15, m_p14, m_low()} : 8'hFF;
        e.irq     = m_irq;
        e.pressed = ~&{m_dpad(), m_btns()};
        e.combo   = m_combo;
        sb.push_back(e);
    endfunction

    task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w,
                        input logic r, input logic [15:0] btn, input logic rs);
        @(posedge clock);
        model_edge();
        #1;
        addr_bus     = a;
        data_in      = d;
        we           = w;
        re           = r;
        snes_buttons = btn;
        rst          = rs;
        if (rs) model_reset();
        cyc++;
        push_expected();
    endtask

    task automatic hold(input int n, input logic [15:0] btn);
        for (int i = 0; i < n; i++) step(16'hFF00, 8'h00, 1'b0, 1'b1, btn, 1'b0);
    endtask

    task automatic wr(input logic [7:0] d, input logic [15:0] btn);
        step(16'hFF00, d, 1'b1, 1'b0, btn, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("data_out", data_out, e.dout);
                chk("sel", {7'd0, sel}, {7'd0, e.sel});
                chk("irq_joypad", {7'd0, irq_joypad}, {7'd0, e.irq});
                chk("button_pressed", {7'd0, button_pressed}, {7'd0, e.pressed});
                chk("combo_reset", {7'd0, combo_reset}, {7'd0, e.combo});
            end
        end
    end

    localparam logic [15:0] BTN_NONE  = 16'hFFFF;
    localparam logic [15:0] BTN_A     = 16'hFEFF;
    localparam logic [15:0] BTN_DN_B  = 16'hFFDE;
    localparam logic [15:0] BTN_RIGHT = 16'hFF7F;
    localparam logic [15:0] BTN_COMBO = 16'hFEF2;
    localparam logic [15:0] BTN_NO_A  = 16'hFFF2;

    initial begin
        logic [15:0] btn;
        logic [15:0] a;
        int          len;
        rst          = 1'b1;
        addr_bus     = 16'h0000;
        data_in      = 8'h00;
        we           = 1'b0;
        re           = 1'b0;
        snes_buttons = BTN_NONE;
        model_reset();

        // Reset and idle, alternating selected and unselected reads
        for (int i = 0; i < 3; i++) step(16'hFF00, 8'h00, 1'b0, 1'b1, BTN_NONE, 1'b1);
        for (int i = 0; i < 30; i++)
            step((i % 2 == 0) ? 16'hFF00 : 16'hFF01, 8'h00, 1'b0, 1'b1, BTN_NONE, 1'b0);

        // A press with a chatter toggle mid-count
        wr(8'h10, BTN_NONE);
        hold(8, BTN_A);
        hold(1, BTN_NONE);
        hold(D + 8, BTN_A);
        hold(D - 1, BTN_NONE);
        hold(1, BTN_A);
        hold(D + 4, BTN_NONE);

        // Line select with Down and B held
        hold(D + 4, BTN_DN_B);
        wr(8'h20, BTN_DN_B); hold(2, BTN_DN_B);
        wr(8'h10, BTN_DN_B); hold(2, BTN_DN_B);
        wr(8'h00, BTN_DN_B); hold(2, BTN_DN_B);
        wr(8'h30, BTN_DN_B); hold(2, BTN_DN_B);

        // Select-caused interrupt with Right held
        hold(D + 4, BTN_RIGHT);
        wr(8'h20, BTN_RIGHT);
        hold(4, BTN_RIGHT);

        // Absent controller
        wr(8'h00, 16'h0000);
        hold(D + 8, 16'h0000);

        // Combo hold, release of A, then reset mid-count
        hold(D + C + 10, BTN_COMBO);
        hold(D + 5, BTN_NO_A);
        hold(D + 20, BTN_COMBO);
        for (int i = 0; i < 2; i++) step(16'hFF00, 8'h00, 1'b0, 1'b1, BTN_COMBO, 1'b1);
        hold(D + C + 5, BTN_COMBO);
        hold(D + 4, BTN_NONE);

        // Randomized segments
        for (int s = 0; s < 40; s++) begin
            btn = 16'hFFFF;
            if ($urandom_range(0, 4) == 0) begin
                btn = BTN_COMBO;
            end else begin
                for (int b = 0; b < 12; b++)
                    if ($urandom_range(0, 3) == 0) btn[b] = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) btn[15:12] = 4'($urandom_range(0, 14));
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, D) : $urandom_range(D, 2 * D + C + 8);
            for (int i = 0; i < len; i++) begin
                a = ($urandom_range(0, 3) != 0) ? 16'hFF00 : 16'($urandom);
                step(a, 8'($urandom), ($urandom_range(0, 9) == 0), 1'($urandom),
                     btn, ($urandom_range(0, 299) == 0));
            end
        end
        hold(4, BTN_NONE);

        @(posedge clock);
        @(posedge clock);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gb_joypad.md
# gb_joypad

Game Boy joypad (P1/JOYP, 0xFF00) register block. Sits directly downstream of `snes_controller`: consumes its active-low 16-bit `snes_buttons` vector, debounces it, maps SNES buttons onto the eight Game Boy inputs, and serves CPU reads/writes of 0xFF00. It raises the joypad interrupt (IF bit 4), drives the top-level `button_pressed` wake signal, and produces a held-combo soft-reset request.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 16'd4096: cycles `snes_buttons` must be unchanged before it is accepted.
- `COMBO_CYCLES`, 24'd4_000_000: cycles Start+Select+A+B must be held before `combo_reset` asserts (about 1 s at `cpu_clock`).

Ports:
- `clock` in 1: `cpu_clock`, the one clock.
- `rst` in 1: asynchronous, active-high reset.
- `addr_bus` in 16: CPU address.
- `data_in` in 8: CPU write data.
- `we` in 1: CPU write strobe.
- `re` in 1: CPU read strobe.
- `snes_buttons` in 16: from `snes_controller`, active-low. Bits 0–11 are B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R. Bits 15:12 read 1 when a controller is present.
- `data_out` out 8: JOYP read value.
- `sel` out 1: `addr_bus == 16'hFF00`.
- `irq_joypad` out 1: one-cycle interrupt request pulse.
- `button_pressed` out 1: any mapped button pressed (debounced).
- `combo_reset` out 1: soft-reset request, level.

## Operation

- **Presence check.** If `snes_buttons[15:12] != 4'hF`, the raw input is replaced by 16'hFFFF (all released). This covers a floating or absent controller.
- **Debounce.**
  - A counter reloads to 0 whenever the presence-checked raw vector differs from the last raw sample.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with no change, the raw vector is copied to `stable[11:0]`. The counter saturates there.
- **Mapping (active-low).**
  - D-pad nibble `{Down, Up, Left, Right}` = `stable{5,4,6,7}`.
  - Button nibble `{Start, Select, B, A}` = `stable{3,2,0,8}`.
  - X, Y, L, R are ignored.
- **Register.**
  - `p14`/`p15` are select bits. A write with `we && sel` loads `p15 = data_in[5]` and `p14 = data_in[4]`. Other bits are ignored.
  - `low_nib = (p14 ? 4'hF : dpad) & (p15 ? 4'hF : btns)`. Both lines selected gives the AND of the two nibbles; neither selected gives 4'hF.
  - `data_out = sel ? {2'b11, p15, p14, low_nib} : 8'hFF` (combinational).
- **Interrupt.**
  - `prev_nib` register; `irq_joypad <= |(prev_nib & ~low_nib)` (any 1→0 bit).
  - Falling edges caused by a select write also fire the interrupt, matching hardware behaviour.
- **Pressed flag.** `button_pressed = ~&{dpad, btns}`, regardless of the select bits.
- **Combo.** Combo is true when Start, Select, A and B are all pressed (debounced).
  - While the combo holds, `combo_cnt` increments.
  - When it reaches `COMBO_CYCLES-1`, `combo_reset` goes to 1 and the counter saturates.
  - Any release clears the counter and `combo_reset` on the next edge.

## Timing

- **Reset values:**
  - `p14 = p15 = 1`
  - `stable = 12'hFFF`
  - `prev_nib = 4'hF`
  - debounce counter and combo counter 0
  - `irq_joypad = 0`, `combo_reset = 0`, `button_pressed = 0`
  - `data_out` = 8'hFF when not selected, 8'hFF when selected
- **Reset mid-operation:** all of the above apply immediately (asynchronous); any debounce or combo in progress is discarded.
- **Read latency:** 0 cycles. `data_out` reflects the registers during the `re` cycle.
- **Write:** select bits change on the `we` edge and are visible to a read on the next cycle.
- **Input latency:** a raw change reaches `stable` after exactly `DEBOUNCE_CYCLES` edges of an unchanged input. `irq_joypad` pulses 1 cycle after that, for exactly 1 cycle.
- **Simultaneous events:** a write and a debounce commit on the same edge both take effect. The interrupt compares against the post-edge `low_nib` on the following cycle.
- **Chatter:** a change arriving before the count completes restarts the count. No partial commit is allowed.
- **Counter widths:** counters must be wide enough for their parameter and never wrap.

## Structure

- **Package `gb_joypad_pkg`** holds:
  - `JOYP_ADDR = 16'hFF00`
  - the SNES bit-index constants (`SNES_B` … `SNES_R`)
  - `SNES_PRESENT_MASK`
- **Sub-module `joy_debounce`** (parameter `WIDTH`, `CYCLES`): vector debounce with reset value all-ones. It is instantiated once, with `WIDTH = 12`.

## Test plan

- **Reset and idle.** Hold `snes_buttons = 16'hFFFF`. Read 0xFF00 gives 8'hFF, `irq_joypad`, `button_pressed` and `combo_reset` are 0, and `sel = 0` gives 8'hFF.
- **A press with chatter.** Write 8'h10 (P15 low). Drive A low (bit 8 = 0) but toggle it once at cycle 100.
  - The read becomes 8'hDE exactly `DEBOUNCE_CYCLES` cycles after the last toggle.
  - One `irq_joypad` pulse occurs.
- **Line select.** Press Down and B, then write 8'h20, 8'h10, 8'h00 and 8'h30. Reads give 8'hE7, 8'hDD, 8'hC5 and 8'hFF respectively.
- **Select-caused interrupt.** With Right held and P14 high, write 8'h20. The read is 8'hEE and `irq_joypad` pulses once.
- **Absent controller.** Drive `snes_buttons = 16'h0000`. After debounce, reads stay 8'hFF/8'hCF-class values with all buttons released, and no interrupt fires.
- **Combo reset.** Hold Start+Select+A+B.
  - `combo_reset` rises `DEBOUNCE_CYCLES + COMBO_CYCLES` cycles after the press.
  - Releasing A clears it 1 cycle after the debounced release.
  - Asserting `rst` mid-count clears the count immediately.
